// File: rtl/tlb_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tlb_op_sequencer
//  Description : Issues COP0 TLB maintenance ops (TLBP/TLBR/TLBWI/TLBWR) onto
//                the TLB op port. After every write it inserts a settle gap
//                and reports completion through registered strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module tlb_op_sequencer #(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  input  logic [1:0]  req_op_i,
  output logic        req_ready_o,
  input  logic        cop0_wired_we_i,
  output logic [1:0]  tlb_op_o,
  input  logic [31:0] tlb_index_in_i,
  output logic        cop0_index_we_o,
  output logic        cop0_entry_we_o,
  output logic        resp_valid_o,
  output logic [1:0]  resp_op_o,
  output logic [31:0] resp_index_o,
  output logic        tlb_busy_o
);

  localparam logic [1:0]  C_OP_TLBP    = 2'b00;
  localparam logic [1:0]  C_OP_TLBR    = 2'b01;
  localparam logic [1:0]  C_TLB_NORMAL = 2'b00;
  localparam logic [1:0]  C_TLB_READ   = 2'b01;
  localparam logic [2:0]  C_GAP_LOAD   = 3'(GAP_CYCLES);
  localparam logic [31:0] C_PROBE_MISS = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PROBE  = 3'd1,
    S_READ   = 3'd2,
    S_WRITE  = 3'd3,
    S_SETTLE = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  state_t      state_q;
  logic [1:0]  op_q;
  logic [2:0]  gap_cnt_q;
  logic [1:0]  tlb_op_q;
  logic        busy_q;
  logic        resp_valid_q;
  logic        index_we_q;
  logic        entry_we_q;
  logic [1:0]  resp_op_q;
  logic [31:0] resp_index_q;

  // Accept only in IDLE; a Wired write holds off the request so the RNG reset lands first.
  assign req_ready_o = rst_n & (state_q == S_IDLE) & ~cop0_wired_we_i;

  assign tlb_op_o        = tlb_op_q;
  assign tlb_busy_o      = busy_q;
  assign resp_valid_o    = resp_valid_q;
  assign cop0_index_we_o = index_we_q;
  assign cop0_entry_we_o = entry_we_q;
  assign resp_op_o       = resp_op_q;
  assign resp_index_o    = resp_index_q;

  // Sequencer FSM; every output is loaded one cycle ahead so it is a clean register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= C_OP_TLBP;
      gap_cnt_q    <= 3'd0;
      tlb_op_q     <= C_TLB_NORMAL;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      index_we_q   <= 1'b0;
      entry_we_q   <= 1'b0;
      resp_op_q    <= 2'b00;
      resp_index_q <= C_PROBE_MISS;
    end else begin
      resp_valid_q <= 1'b0;
      index_we_q   <= 1'b0;
      entry_we_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            op_q <= req_op_i;
            if (req_op_i == C_OP_TLBP) begin
              state_q  <= S_PROBE;
              tlb_op_q <= C_TLB_NORMAL;
            end else if (req_op_i == C_OP_TLBR) begin
              state_q  <= S_READ;
              tlb_op_q <= C_TLB_READ;
            end else begin
              // Write op codes on the request map directly onto the TLB op codes.
              state_q  <= S_WRITE;
              tlb_op_q <= req_op_i;
              busy_q   <= 1'b1;
            end
          end
        end
        S_PROBE: begin
          resp_index_q <= tlb_index_in_i;
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          index_we_q   <= 1'b1;
          resp_op_q    <= op_q;
        end
        S_READ: begin
          // TLBR stays on the op port through RESP so the entry outputs stay valid for COP0.
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          entry_we_q   <= 1'b1;
          resp_op_q    <= op_q;
        end
        S_WRITE: begin
          tlb_op_q  <= C_TLB_NORMAL;
          gap_cnt_q <= C_GAP_LOAD;
          state_q   <= S_SETTLE;
        end
        S_SETTLE: begin
          gap_cnt_q <= gap_cnt_q - 3'd1;
          if (gap_cnt_q == 3'd1) begin
            state_q      <= S_RESP;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_op_q    <= op_q;
          end
        end
        S_RESP: begin
          state_q  <= S_IDLE;
          tlb_op_q <= C_TLB_NORMAL;
        end
        default: begin
          state_q  <= S_IDLE;
          tlb_op_q <= C_TLB_NORMAL;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tlb_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tlb_op_sequencer
//  Description : Self-checking bench for tlb_op_sequencer. Instance A uses a
//                one-cycle settle gap, instance B a three-cycle gap.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tlb_op_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_valid_b;
  logic [1:0]  req_op;
  logic        wired_we;
  logic [31:0] tlb_index_in;

  logic        a_ready, a_index_we, a_entry_we, a_resp_valid, a_busy;
  logic [1:0]  a_tlb_op, a_resp_op;
  logic [31:0] a_resp_index;
  logic        b_ready, b_index_we, b_entry_we, b_resp_valid, b_busy;
  logic [1:0]  b_tlb_op, b_resp_op;
  logic [31:0] b_resp_index;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] idx;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] idx;
    logic        wired;
  } vec_t;
  vec_t vecs[8];

  tlb_op_sequencer #(.GAP_CYCLES(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_op_i(req_op), .req_ready_o(a_ready),
    .cop0_wired_we_i(wired_we), .tlb_op_o(a_tlb_op), .tlb_index_in_i(tlb_index_in),
    .cop0_index_we_o(a_index_we), .cop0_entry_we_o(a_entry_we),
    .resp_valid_o(a_resp_valid), .resp_op_o(a_resp_op), .resp_index_o(a_resp_index),
    .tlb_busy_o(a_busy)
  );

  tlb_op_sequencer #(.GAP_CYCLES(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_b), .req_op_i(req_op), .req_ready_o(b_ready),
    .cop0_wired_we_i(wired_we), .tlb_op_o(b_tlb_op), .tlb_index_in_i(tlb_index_in),
    .cop0_index_we_o(b_index_we), .cop0_entry_we_o(b_entry_we),
    .resp_valid_o(b_resp_valid), .resp_op_o(b_resp_op), .resp_index_o(b_resp_index),
    .tlb_busy_o(b_busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Spec timing, k = cycles after the accept cycle.
  function automatic int lat(logic [1:0] op, int gap);
    return op[1] ? 2 + gap : 2;
  endfunction
  function automatic logic [1:0] exp_op(logic [1:0] op, int k);
    if (op == 2'b01) return (k == 1 || k == 2) ? 2'b01 : 2'b00;
    if (op[1])       return (k == 1) ? op : 2'b00;
    return 2'b00;
  endfunction
  function automatic logic exp_busy(logic [1:0] op, int k, int gap);
    return op[1] && k >= 1 && k <= 1 + gap;
  endfunction

  // Scoreboard on instance A: every completion must match the oldest accepted request.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_resp_valid) begin
        if (sb.size() == 0) begin
          chk("A unexpected resp_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("A resp_op", a_resp_op, e.op);
          if (e.op == 2'b00) chk("A resp_index", a_resp_index, e.idx);
          chk("A cop0_index_we", a_index_we, e.op == 2'b00);
          chk("A cop0_entry_we", a_entry_we, e.op == 2'b01);
        end
      end else if (a_index_we || a_entry_we) begin
        chk("A stray strobe", 1, 0);
      end
    end
  end

  task automatic chk_reset(string tag);
    chk({tag, " A tlb_op"}, a_tlb_op, 0);
    chk({tag, " A req_ready"}, a_ready, 0);
    chk({tag, " A resp_valid"}, a_resp_valid, 0);
    chk({tag, " A index_we"}, a_index_we, 0);
    chk({tag, " A entry_we"}, a_entry_we, 0);
    chk({tag, " A busy"}, a_busy, 0);
    chk({tag, " A resp_index"}, a_resp_index, 32'h8000_0000);
    chk({tag, " A resp_op"}, a_resp_op, 0);
    chk({tag, " B tlb_op"}, b_tlb_op, 0);
    chk({tag, " B busy"}, b_busy, 0);
    chk({tag, " B resp_index"}, b_resp_index, 32'h8000_0000);
  endtask

  // One request on both instances; per-cycle waveform checked against spec timing.
  task automatic do_req(logic [1:0] op, logic [31:0] idx, logic wired);
    req_valid = 1; req_valid_b = 1; req_op = op; tlb_index_in = idx; wired_we = wired;
    if (wired) begin
      @(negedge clk);
      chk("A ready under wired_we", a_ready, 0);
      chk("B ready under wired_we", b_ready, 0);
      @(posedge clk); #1;
      wired_we = 0;
    end
    @(negedge clk);
    chk("A ready at accept", a_ready, 1);
    chk("B ready at accept", b_ready, 1);
    chk("A tlb_op at accept", a_tlb_op, 0);
    sb.push_back('{op: op, idx: idx});
    @(posedge clk); #1;
    req_valid = 0; req_valid_b = 0;
    for (int k = 1; k <= lat(op, 3) + 1; k++) begin
      if (k == 2) tlb_index_in = $urandom;
      @(negedge clk);
      chk($sformatf("A tlb_op op=%0d k=%0d", op, k), a_tlb_op, exp_op(op, k));
      chk($sformatf("A busy op=%0d k=%0d", op, k), a_busy, exp_busy(op, k, 1));
      chk($sformatf("A resp_valid op=%0d k=%0d", op, k), a_resp_valid, k == lat(op, 1));
      chk($sformatf("A ready op=%0d k=%0d", op, k), a_ready, k > lat(op, 1));
      chk($sformatf("B tlb_op op=%0d k=%0d", op, k), b_tlb_op, exp_op(op, k));
      chk($sformatf("B busy op=%0d k=%0d", op, k), b_busy, exp_busy(op, k, 3));
      chk($sformatf("B resp_valid op=%0d k=%0d", op, k), b_resp_valid, k == lat(op, 3));
      if (k == lat(op, 3) && op == 2'b00)
        chk("B resp_index", b_resp_index, idx);
      @(posedge clk); #1;
    end
  endtask

  logic [1:0] bb_op   [1:6];
  logic       bb_busy [1:6];

  initial begin
    vecs[0] = '{op: 2'b00, idx: 32'h0000_0005, wired: 1'b0};
    vecs[1] = '{op: 2'b00, idx: 32'h8000_0000, wired: 1'b0};
    vecs[2] = '{op: 2'b01, idx: 32'h0000_0000, wired: 1'b0};
    vecs[3] = '{op: 2'b10, idx: 32'h0000_0000, wired: 1'b0};
    vecs[4] = '{op: 2'b11, idx: 32'h0000_0000, wired: 1'b0};
    vecs[5] = '{op: 2'b11, idx: 32'h0000_0000, wired: 1'b1};
    vecs[6] = '{op: 2'b00, idx: 32'h0000_001F, wired: 1'b1};
    vecs[7] = '{op: 2'b01, idx: 32'h1234_5678, wired: 1'b0};
    bb_op   = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00};
    bb_busy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    clk = 0; rst_n = 1; req_valid = 0; req_valid_b = 0; req_op = 0;
    wired_we = 0; tlb_index_in = 0;
    #1 rst_n = 0;
    #1 chk_reset("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("A ready after release", a_ready, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) do_req(vecs[i].op, vecs[i].idx, vecs[i].wired);

    // Back-to-back TLBWI then TLBWR on instance A with req_valid held high.
    req_valid = 1; req_valid_b = 0; req_op = 2'b10; wired_we = 0;
    @(negedge clk);
    chk("A b2b first accept", a_ready, 1);
    sb.push_back('{op: 2'b10, idx: 0});
    @(posedge clk); #1;
    req_op = 2'b11;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 5) chk($sformatf("A b2b tlb_op k=%0d", k), a_tlb_op, bb_op[k]);
      chk($sformatf("A b2b busy k=%0d", k), a_busy, bb_busy[k]);
      if (k <= 4) chk($sformatf("A b2b ready k=%0d", k), a_ready, k == 4);
      if (k == 4) sb.push_back('{op: 2'b11, idx: 0});
      @(posedge clk); #1;
      if (k == 4) req_valid = 0;
    end
    repeat (3) @(posedge clk);
    #1 chk("A scoreboard drained", sb.size(), 0);

    // Reset in the middle of a TLBWR.
    req_valid = 1; req_valid_b = 1; req_op = 2'b11;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 0; req_valid_b = 0;
    @(negedge clk);
    chk("A tlb_op before reset", a_tlb_op, 2'b11);
    chk("B tlb_op before reset", b_tlb_op, 2'b11);
    #1 rst_n = 0;
    #1 chk_reset("mid-write reset");
    sb.delete();
    @(posedge clk); #1 rst_n = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("A post-reset resp_valid c=%0d", k), a_resp_valid, 0);
      chk($sformatf("B post-reset resp_valid c=%0d", k), b_resp_valid, 0);
      chk($sformatf("A post-reset ready c=%0d", k), a_ready, 1);
      chk($sformatf("A post-reset busy c=%0d", k), a_busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
